keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 2048: clock cycles each column is driven before advancing.
REQ-002 Parameter DEBOUNCE_CNT, default 500000: consecutive stable cycles required for press or release (10 ms at 50 MHz).
REQ-003 Clk  input  1  single system clock; all logic on rising edge.
REQ-004 Rst_n  input  1  reset, synchronous, active-low.
REQ-005 rows  input  4  keypad row lines, active-low with external pull-ups, asynchronous to Clk.
REQ-006 cols  output  4  keypad column drive, active-low, at most one bit low at any time.
REQ-007 key_valid  output  1  one-cycle pulse per debounced key press.
REQ-008 key_code  output  4  code of the pressed key, valid while key_valid=1.
REQ-009 entry_value  output  11  unsigned number currently being typed, live, for the display.
REQ-010 operand  output  11  entry value captured on an operator or equals key.
REQ-011 operand_op  output  4  key code (10..13 or 15) that captured operand.
REQ-012 operand_valid  output  1  one-cycle pulse when operand/operand_op update.

Function
REQ-013 Key map (row r, col c -> code): r0: 1,2,3,10(+); r1: 4,5,6,11(-); r2: 7,8,9,12(*); r3: 14(clear),0,15(equals),13(/).
REQ-014 rows shall pass through a 2-flop synchronizer before any use; all row references below mean synchronized rows.
REQ-015 FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-016 SCAN: cols cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per SCAN_DIV cycles; rows sampled on the last dwell cycle; any row low -> capture (row, col) and go to PRESS_DB with cols frozen.
REQ-017 Multiple rows low in one sample: lowest row index wins.
REQ-018 PRESS_DB: counter increments while captured row stays low; reaching DEBOUNCE_CNT -> key_valid=1 for exactly the next cycle, then HELD; captured row high before that -> counter cleared, back to SCAN at the next column.
REQ-019 HELD: cols frozen, no further key_valid; all rows high -> RELEASE_DB.
REQ-020 RELEASE_DB: DEBOUNCE_CNT consecutive cycles of all rows high -> SCAN; any row low -> HELD, counter cleared.
REQ-021 Digit key d: entry_value <= entry_value*10 + d if the result is <= 2047, else the key is ignored (entry_value unchanged, key_valid still pulses).
REQ-022 Operator key (10..13) or equals (15): operand <= entry_value, operand_op <= code, operand_valid pulses in the cycle after key_valid, entry_value <= 0 in that same cycle.
REQ-023 Clear key (14): entry_value <= 0; operand and operand_op unchanged; no operand_valid.
REQ-024 Multiply-by-10 arithmetic is computed at >= 15 bits before the 2047 comparison; no truncation wrap is allowed.

Reset
REQ-025 Rst_n=0 at a rising edge: state SCAN, cols=1110, all counters 0, synchronizer flops 1, key_valid=0, key_code=0, entry_value=0, operand=0, operand_op=0, operand_valid=0.
REQ-026 Reset mid-debounce or mid-HELD aborts without a key_valid pulse; a key still held after reset is detected fresh through PRESS_DB.

Configuration
REQ-027 Macro KEYPAD_ENTRY_EN defined: number-entry logic (REQ-021..REQ-024) is compiled in.
REQ-028 Macro KEYPAD_ENTRY_EN undefined: entry_value, operand, operand_op and operand_valid are constant 0; scanner and key_valid/key_code behave identically.

Structure
REQ-029 Shared package calc_pkg holds: key code constants (KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_DIV=13, KEY_CLR=14, KEY_EQ=15), FSM state enum, operand width constant OPND_W=11.
REQ-030 One sub-module, key_debounce (counter + compare against DEBOUNCE_CNT), instantiated once and shared by PRESS_DB and RELEASE_DB.

Verification (DEBOUNCE_CNT=8, SCAN_DIV=4 in bench)
REQ-031 Press r1c2 clean for 20 cycles -> single key_valid, key_code=6; release -> no further pulse.
REQ-032 Press r0c0 bouncing low/high every 3 cycles for 12 cycles, then stable -> exactly one key_valid, key_code=1.
REQ-033 Keys 2,0,4,7 -> entry_value 2047; then keys 2,0,4,8 after clear -> entry_value stays 204.
REQ-034 Keys 1,2,+ -> operand_valid one cycle after key_valid with operand=12, operand_op=10, entry_value=0.
REQ-035 Rows r0 and r2 low together on col1 -> key_code=2.
REQ-036 Rst_n low during PRESS_DB -> no key_valid, all outputs 0, cols=1110 next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : calc_pkg                                                   |
// | Purpose  : Shared definitions for the keypad scanner / number entry.  |
// |            Key code constants, scanner FSM state type, operand width, |
// |            and the row/column to key-code lookup.                     |
// | Ports    : none (package)                                             |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package calc_pkg;

   localparam int OPND_W    = 11;
   // Width for the multiply-by-10 step; 2047*10+9 fits without wrapping.
   localparam int MUL_W     = 15;
   localparam int ENTRY_MAX = 2047;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_DIV = 4'd13;
   localparam logic [3:0] KEY_CLR = 4'd14;
   localparam logic [3:0] KEY_EQ  = 4'd15;

   typedef enum logic [1:0] {
      ST_SCAN       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } scan_state_e;

   // Physical key layout: row r, column c -> key code.
   function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                             input logic [1:0] col);
      logic [3:0] code;
      code = 4'd0;
      case ({row, col})
         4'b0000: code = 4'd1;
         4'b0001: code = 4'd2;
         4'b0010: code = 4'd3;
         4'b0011: code = KEY_ADD;
         4'b0100: code = 4'd4;
         4'b0101: code = 4'd5;
         4'b0110: code = 4'd6;
         4'b0111: code = KEY_SUB;
         4'b1000: code = 4'd7;
         4'b1001: code = 4'd8;
         4'b1010: code = 4'd9;
         4'b1011: code = KEY_MUL;
         4'b1100: code = KEY_CLR;
         4'b1101: code = 4'd0;
         4'b1110: code = KEY_EQ;
         default: code = KEY_DIV;
      endcase
      return code;
   endfunction

   // Lowest-index active row wins when several rows are low together.
   function automatic logic [1:0] lowest_row(input logic [3:0] rows_low);
      logic [1:0] idx;
      idx = 2'd3;
      if (rows_low[0])      idx = 2'd0;
      else if (rows_low[1]) idx = 2'd1;
      else if (rows_low[2]) idx = 2'd2;
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : key_debounce                                               |
// | Purpose  : Stable-cycle counter shared by press and release debounce. |
// | Ports    : clk       - system clock                                   |
// |            rst_n     - synchronous active-low reset                   |
// |            clr       - clear the count                                |
// |            inc       - count one more stable cycle                    |
// |            at_limit  - count has reached DEBOUNCE_CNT-1, so the next  |
// |                        stable cycle completes the debounce            |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module key_debounce #(
   parameter int DEBOUNCE_CNT = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign at_limit = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         // Wrap to zero on completion so the next debounce starts clean.
         cnt_d = at_limit ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : keypad_scan                                                |
// | Purpose  : 4x4 keypad column scanner with press/release debounce and  |
// |            optional decimal number entry for a calculator front end.  |
// | Config   : define KEYPAD_ENTRY_EN to build the number-entry logic;    |
// |            otherwise entry_value/operand/operand_op/operand_valid     |
// |            are tied to 0.                                             |
// | Ports    : clk, rst_n     - clock, synchronous active-low reset       |
// |            rows[3:0]      - row inputs, active-low, asynchronous      |
// |            cols[3:0]      - column drive, active-low, one-hot-low     |
// |            key_valid      - one-cycle pulse per debounced press       |
// |            key_code[3:0]  - code of pressed key, valid with key_valid |
// |            entry_value    - number being typed                        |
// |            operand        - value captured by operator/equals         |
// |            operand_op     - code of the capturing key                 |
// |            operand_valid  - one-cycle pulse when operand updates      |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module keypad_scan
   import calc_pkg::*;
#(
   parameter int SCAN_DIV     = 2048,
   parameter int DEBOUNCE_CNT = 500000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        rows,
   output logic [3:0]        cols,
   output logic              key_valid,
   output logic [3:0]        key_code,
   output logic [OPND_W-1:0] entry_value,
   output logic [OPND_W-1:0] operand,
   output logic [3:0]        operand_op,
   output logic              operand_valid
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   scan_state_e      state_d, state_q;
   logic [3:0]       rows_meta_d, rows_meta_q;
   logic [3:0]       rows_sync_d, rows_sync_q;
   logic [1:0]       col_idx_d, col_idx_q;
   logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
   logic [1:0]       cap_row_d, cap_row_q;
   logic             key_valid_d, key_valid_q;
   logic [3:0]       key_code_d, key_code_q;

   logic [3:0]       rows_low;
   logic             any_low;
   logic             cap_low;
   logic             dbnc_clr;
   logic             dbnc_inc;
   logic             dbnc_at_limit;

   key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (dbnc_clr),
      .inc      (dbnc_inc),
      .at_limit (dbnc_at_limit)
   );

   assign cols      = ~(4'b0001 << col_idx_q);
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;

   always_comb begin
      rows_meta_d = rows;
      rows_sync_d = rows_meta_q;
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      div_cnt_d   = div_cnt_q;
      cap_row_d   = cap_row_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      dbnc_clr    = 1'b1;
      dbnc_inc    = 1'b0;

      rows_low = ~rows_sync_q;
      any_low  = |rows_low;
      cap_low  = rows_low[cap_row_q];

      case (state_q)
         ST_SCAN: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (any_low) begin
                  // Column stays frozen on col_idx_q while debouncing.
                  cap_row_d = lowest_row(rows_low);
                  state_d   = ST_PRESS_DB;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         ST_PRESS_DB: begin
            if (cap_low) begin
               dbnc_clr = 1'b0;
               dbnc_inc = 1'b1;
               if (dbnc_at_limit) begin
                  state_d     = ST_HELD;
                  key_valid_d = 1'b1;
                  key_code_d  = key_lookup(cap_row_q, col_idx_q);
               end
            end else begin
               // Bounce: give up and resume scanning at the next column.
               state_d   = ST_SCAN;
               col_idx_d = col_idx_q + 2'd1;
            end
         end

         ST_HELD: begin
            if (!any_low) begin
               state_d = ST_RELEASE_DB;
            end
         end

         ST_RELEASE_DB: begin
            if (!any_low) begin
               dbnc_clr = 1'b0;
               dbnc_inc = 1'b1;
               if (dbnc_at_limit) begin
                  state_d = ST_SCAN;
               end
            end else begin
               state_d = ST_HELD;
            end
         end

         default: begin
            state_d = ST_SCAN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_SCAN;
         rows_meta_q <= 4'hF;
         rows_sync_q <= 4'hF;
         col_idx_q   <= 2'd0;
         div_cnt_q   <= '0;
         cap_row_q   <= 2'd0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
      end else begin
         state_q     <= state_d;
         rows_meta_q <= rows_meta_d;
         rows_sync_q <= rows_sync_d;
         col_idx_q   <= col_idx_d;
         div_cnt_q   <= div_cnt_d;
         cap_row_q   <= cap_row_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

`ifdef KEYPAD_ENTRY_EN
   logic [OPND_W-1:0] entry_value_d, entry_value_q;
   logic [OPND_W-1:0] operand_d, operand_q;
   logic [3:0]        operand_op_d, operand_op_q;
   logic              operand_valid_d, operand_valid_q;
   logic [MUL_W-1:0]  entry_x10;

   assign entry_value   = entry_value_q;
   assign operand       = operand_q;
   assign operand_op    = operand_op_q;
   assign operand_valid = operand_valid_q;

   always_comb begin
      entry_value_d   = entry_value_q;
      operand_d       = operand_q;
      operand_op_d    = operand_op_q;
      operand_valid_d = 1'b0;
      // Wide enough that an overflowing digit compares as too large
      // rather than wrapping back into range.
      entry_x10 = MUL_W'(entry_value_q) * MUL_W'(10) + MUL_W'(key_code_q);

      if (key_valid_q) begin
         if (key_code_q <= 4'd9) begin
            if (entry_x10 <= MUL_W'(ENTRY_MAX)) begin
               entry_value_d = entry_x10[OPND_W-1:0];
            end
         end else if (key_code_q == KEY_CLR) begin
            entry_value_d = '0;
         end else begin
            operand_d       = entry_value_q;
            operand_op_d    = key_code_q;
            operand_valid_d = 1'b1;
            entry_value_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         entry_value_q   <= '0;
         operand_q       <= '0;
         operand_op_q    <= 4'd0;
         operand_valid_q <= 1'b0;
      end else begin
         entry_value_q   <= entry_value_d;
         operand_q       <= operand_d;
         operand_op_q    <= operand_op_d;
         operand_valid_q <= operand_valid_d;
      end
   end
`else
   assign entry_value   = '0;
   assign operand       = '0;
   assign operand_op    = 4'd0;
   assign operand_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_keypad_scan                                             |
// | Purpose  : Directed self-checking bench for keypad_scan with a        |
// |            behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_CNT=8).   |
// |            Entry checks follow KEYPAD_ENTRY_EN.                       |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [10:0] entry_value;
   logic [10:0] operand;
   logic [3:0]  operand_op;
   logic        operand_valid;

   logic [15:0] pressed = 16'h0000;

   int          checks = 0;
   int          failures = 0;
   int          kv_count = 0;
   int          ov_count = 0;
   logic [3:0]  last_code = 4'd0;

   keypad_scan #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rows          (rows),
      .cols          (cols),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .entry_value   (entry_value),
      .operand       (operand),
      .operand_op    (operand_op),
      .operand_valid (operand_valid)
   );

   always #5 clk = ~clk;

   // Key matrix: a closed key pulls its row low while its column is driven low.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (key_valid) begin
         kv_count++;
         last_code = key_code;
      end
      if (operand_valid) ov_count++;
   end

   // Press key (r,c), wait (bounded) for a key_valid, hold, release, settle.
   task automatic tap_key(input int r, input int c, input int hold);
      int base;
      base = kv_count;
      pressed[r*4+c] = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         if (kv_count != base) break;
      end
      repeat (hold) @(negedge clk);
      pressed[r*4+c] = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%0b exp=0", key_valid); end
      checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_key_code got=%0d exp=0", key_code); end
      checks++; if (cols !== 4'b1110) begin failures++; $display("FAIL reset_cols got=%b exp=1110", cols); end
      checks++; if (entry_value !== 11'd0) begin failures++; $display("FAIL reset_entry got=%0d exp=0", entry_value); end
      checks++; if (operand !== 11'd0) begin failures++; $display("FAIL reset_operand got=%0d exp=0", operand); end
      checks++; if (operand_op !== 4'd0) begin failures++; $display("FAIL reset_operand_op got=%0d exp=0", operand_op); end
      checks++; if (operand_valid !== 1'b0) begin failures++; $display("FAIL reset_operand_valid got=%0b exp=0", operand_valid); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (cols !== 4'b1110) begin failures++; $display("FAIL reset_cols_first got=%b exp=1110", cols); end
   endtask

   task automatic test_scan_sequence;
      logic [3:0] seen [0:3];
      // Idle scan: each column pattern held SCAN_DIV=4 cycles, in order.
      for (int k = 0; k < 4; k++) begin
         repeat (4) @(negedge clk);
         seen[k] = cols;
      end
      checks++; if (seen[0] !== 4'b1101) begin failures++; $display("FAIL scan_col1 got=%b exp=1101", seen[0]); end
      checks++; if (seen[1] !== 4'b1011) begin failures++; $display("FAIL scan_col2 got=%b exp=1011", seen[1]); end
      checks++; if (seen[2] !== 4'b0111) begin failures++; $display("FAIL scan_col3 got=%b exp=0111", seen[2]); end
      checks++; if (seen[3] !== 4'b1110) begin failures++; $display("FAIL scan_wrap got=%b exp=1110", seen[3]); end
   endtask

   task automatic test_clean_press;
      int base;
      base = kv_count;
      tap_key(1, 2, 20);
      checks++; if (kv_count - base !== 1) begin failures++; $display("FAIL clean_pulses got=%0d exp=1", kv_count - base); end
      checks++; if (last_code !== 4'd6) begin failures++; $display("FAIL clean_code got=%0d exp=6", last_code); end
   endtask

   task automatic test_bounce;
      int base;
      base = kv_count;
      for (int ph = 0; ph < 4; ph++) begin
         pressed[0] = (ph % 2 == 0);
         repeat (3) @(negedge clk);
      end
      tap_key(0, 0, 10);
      checks++; if (kv_count - base !== 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", kv_count - base); end
      checks++; if (last_code !== 4'd1) begin failures++; $display("FAIL bounce_code got=%0d exp=1", last_code); end
   endtask

   task automatic test_multi_row;
      int base;
      base = kv_count;
      pressed[2*4+1] = 1'b1;
      tap_key(0, 1, 5);
      pressed[2*4+1] = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (kv_count - base !== 1) begin failures++; $display("FAIL multi_pulses got=%0d exp=1", kv_count - base); end
      checks++; if (last_code !== 4'd2) begin failures++; $display("FAIL multi_code got=%0d exp=2", last_code); end
   endtask

`ifdef KEYPAD_ENTRY_EN
   task automatic test_entry_limit;
      int ov_base;
      ov_base = ov_count;
      tap_key(3, 0, 3);                 // clear
      checks++; if (entry_value !== 11'd0) begin failures++; $display("FAIL entry_clear got=%0d exp=0", entry_value); end
      tap_key(0, 1, 3);                 // 2
      checks++; if (entry_value !== 11'd2) begin failures++; $display("FAIL entry_first got=%0d exp=2", entry_value); end
      tap_key(3, 1, 3);                 // 0
      tap_key(1, 0, 3);                 // 4
      tap_key(2, 0, 3);                 // 7
      checks++; if (entry_value !== 11'd2047) begin failures++; $display("FAIL entry_2047 got=%0d exp=2047", entry_value); end
      tap_key(3, 1, 3);                 // 0 -> 20470 rejected
      checks++; if (entry_value !== 11'd2047) begin failures++; $display("FAIL entry_overflow got=%0d exp=2047", entry_value); end
      tap_key(3, 0, 3);                 // clear
      tap_key(0, 1, 3);                 // 2
      tap_key(3, 1, 3);                 // 0
      tap_key(1, 0, 3);                 // 4
      tap_key(2, 1, 3);                 // 8 -> 2048 rejected
      checks++; if (entry_value !== 11'd204) begin failures++; $display("FAIL entry_2048 got=%0d exp=204", entry_value); end
      checks++; if (ov_count !== ov_base) begin failures++; $display("FAIL entry_no_operand got=%0d exp=%0d", ov_count, ov_base); end
   endtask

   task automatic test_operator;
      bit seen_kv;
      tap_key(3, 0, 3);                 // clear
      tap_key(0, 0, 3);                 // 1
      tap_key(0, 1, 3);                 // 2
      checks++; if (entry_value !== 11'd12) begin failures++; $display("FAIL op_entry got=%0d exp=12", entry_value); end
      seen_kv = 1'b0;
      pressed[0*4+3] = 1'b1;            // +
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (key_valid) begin seen_kv = 1'b1; break; end
      end
      checks++; if (seen_kv !== 1'b1) begin failures++; $display("FAIL op_key_valid got=%0b exp=1", seen_kv); end
      checks++; if (operand_valid !== 1'b0) begin failures++; $display("FAIL op_valid_early got=%0b exp=0", operand_valid); end
      @(negedge clk);
      checks++; if (operand_valid !== 1'b1) begin failures++; $display("FAIL op_valid got=%0b exp=1", operand_valid); end
      checks++; if (operand !== 11'd12) begin failures++; $display("FAIL op_operand got=%0d exp=12", operand); end
      checks++; if (operand_op !== 4'd10) begin failures++; $display("FAIL op_code got=%0d exp=10", operand_op); end
      checks++; if (entry_value !== 11'd0) begin failures++; $display("FAIL op_entry_zero got=%0d exp=0", entry_value); end
      @(negedge clk);
      checks++; if (operand_valid !== 1'b0) begin failures++; $display("FAIL op_valid_width got=%0b exp=0", operand_valid); end
      pressed[0*4+3] = 1'b0;
      repeat (40) @(negedge clk);
      tap_key(0, 2, 3);                 // 3
      tap_key(3, 0, 3);                 // clear keeps operand
      checks++; if (operand !== 11'd12 || operand_op !== 4'd10) begin failures++; $display("FAIL op_after_clear got=%0d/%0d exp=12/10", operand, operand_op); end
      tap_key(1, 1, 3);                 // 5 so entry is non-zero before reset test
   endtask
`else
   task automatic test_entry_disabled;
      tap_key(1, 1, 3);                 // 5
      tap_key(0, 3, 3);                 // +
      checks++; if (entry_value !== 11'd0) begin failures++; $display("FAIL dis_entry got=%0d exp=0", entry_value); end
      checks++; if (operand !== 11'd0 || operand_op !== 4'd0) begin failures++; $display("FAIL dis_operand got=%0d/%0d exp=0/0", operand, operand_op); end
      checks++; if (ov_count !== 0) begin failures++; $display("FAIL dis_operand_valid got=%0d exp=0", ov_count); end
   endtask
`endif

   task automatic test_reset_mid_press;
      int base;
      int run;
      base = kv_count;
      run = 0;
      pressed[1*4+2] = 1'b1;            // key 6 on column 2
      // Column 2 held beyond its 4-cycle dwell means it is frozen in debounce.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cols == 4'b1011) run++; else run = 0;
         if (run == 6) break;
      end
      checks++; if (run !== 6) begin failures++; $display("FAIL midrst_frozen got=%0d exp=6", run); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL midrst_key_valid got=%0b exp=0", key_valid); end
      checks++; if (cols !== 4'b1110) begin failures++; $display("FAIL midrst_cols got=%b exp=1110", cols); end
      checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL midrst_key_code got=%0d exp=0", key_code); end
      checks++; if (entry_value !== 11'd0 || operand !== 11'd0 || operand_op !== 4'd0 || operand_valid !== 1'b0) begin
         failures++; $display("FAIL midrst_entry got=%0d/%0d/%0d/%0b exp=0/0/0/0", entry_value, operand, operand_op, operand_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (kv_count !== base) begin failures++; $display("FAIL midrst_no_pulse got=%0d exp=%0d", kv_count, base); end
      // Key is still held: it must be picked up again from scratch.
      pressed[1*4+2] = 1'b0;
      tap_key(1, 2, 5);
      checks++; if (kv_count - base !== 1) begin failures++; $display("FAIL midrst_fresh got=%0d exp=1", kv_count - base); end
      checks++; if (last_code !== 4'd6) begin failures++; $display("FAIL midrst_code got=%0d exp=6", last_code); end
   endtask

   initial begin
      test_reset();
      test_scan_sequence();
      test_clean_press();
      test_bounce();
      test_multi_row();
`ifdef KEYPAD_ENTRY_EN
      test_entry_limit();
      test_operator();
`else
      test_entry_disabled();
`endif
      test_reset_mid_press();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
